// File: rtl/coprocessor0_exception_unit_pkg.sv
// CP0 shared types and constants: register map, exception vector, exception
// codes and the packed register layouts used by the exception unit.
package coprocessor0_params;

    typedef logic [31:0] AddressData;
    typedef logic [31:0] EPCData;

    // CP0 register numbers (all live at select 0)
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [2:0] CP0_SEL_DEFAULT  = 3'd0;

    localparam AddressData EXCEPTION_VECTOR = 32'hBFC0_0380;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] mask;
        logic [5:0] zero_7_2;
        logic       exception_level;
        logic       interrupt_enabled;
    } StatusData;

    typedef struct packed {
        logic        delay_slot;
        logic        timer_interrupt;
        logic [13:0] zero_29_16;
        logic [5:0]  hardware_interrupt;
        logic [1:0]  software_interrupt;
        logic        zero_7;
        logic [4:0]  exception_code;
        logic [1:0]  zero_1_0;
    } CauseData;

    typedef struct packed {
        logic        enable;
        logic [4:0]  register_number;
        logic [2:0]  select;
        logic [31:0] data;
    } WBToCP0Data;

    // Address-error exceptions are the only ones that latch BadVAddr
    function automatic logic is_address_error(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/coprocessor0_timer.sv
// Count/Compare timer: Count advances every second cycle, and a sticky
// timer interrupt is raised the cycle after Count matches Compare.
module coprocessor0_timer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        count_write,
    input  logic        compare_write,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_interrupt
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;
    logic        r_timer_interrupt;

    // Half-rate counter with write override; compare match sets a sticky flag
    // that a Compare write clears (the clear beats a coincident match)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count           <= '0;
            r_compare         <= '0;
            r_toggle          <= 1'b0;
            r_timer_interrupt <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
            if (count_write)
                r_count <= write_data;
            else if (r_toggle)
                r_count <= r_count + 32'd1;
            if (compare_write)
                r_compare <= write_data;
            if (compare_write)
                r_timer_interrupt <= 1'b0;
            else if (r_count == r_compare)
                r_timer_interrupt <= 1'b1;
        end
    end

    assign count           = r_count;
    assign compare         = r_compare;
    assign timer_interrupt = r_timer_interrupt;

endmodule

// File: rtl/coprocessor0_exception_unit.sv
// CP0 exception unit: Status/Cause/EPC/BadVAddr state, MTC0/MFC0 access,
// exception entry, ERET return and the one-cycle flush/redirect pulse.
module coprocessor0_exception_unit
    import coprocessor0_params::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  WBToCP0Data  wb_to_cp0,
    input  logic [4:0]  read_register,
    input  logic [2:0]  read_select,
    output logic [31:0] read_data,
    input  logic        exception_valid,
    input  logic [4:0]  exception_code,
    input  AddressData  exception_pc,
    input  logic        exception_delay_slot,
    input  logic [31:0] exception_bad_vaddr,
    input  logic        eret_valid,
    input  logic [5:0]  hardware_interrupt,
    output logic        interrupt_pending,
    output logic        flush,
    output AddressData  redirect_pc
);

    logic [7:0]  r_mask;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    EPCData      r_epc;
    logic [31:0] r_bad_vaddr;
    logic        r_flush;
    AddressData  r_redirect_pc;

    logic        w_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_interrupt;
    StatusData   w_status;
    CauseData    w_cause;

    // An exception or ERET in the same cycle swallows the MTC0 entirely
    assign w_mtc0       = wb_to_cp0.enable & ~exception_valid & ~eret_valid
                          & (wb_to_cp0.select == CP0_SEL_DEFAULT);
    assign w_wr_count   = w_mtc0 & (wb_to_cp0.register_number == CP0_REG_COUNT);
    assign w_wr_compare = w_mtc0 & (wb_to_cp0.register_number == CP0_REG_COMPARE);

    coprocessor0_timer u_timer (
        .clock           (clock),
        .reset_n         (reset_n),
        .count_write     (w_wr_count),
        .compare_write   (w_wr_compare),
        .write_data      (wb_to_cp0.data),
        .count           (w_count),
        .compare         (w_compare),
        .timer_interrupt (w_timer_interrupt)
    );

    // Assemble architectural Status/Cause views from the stored fields
    always_comb begin
        w_status                   = '0;
        w_status.bev               = 1'b1;
        w_status.mask              = r_mask;
        w_status.exception_level   = r_exl;
        w_status.interrupt_enabled = r_ie;
        w_cause                    = '0;
        w_cause.delay_slot         = r_bd;
        w_cause.timer_interrupt    = w_timer_interrupt;
        w_cause.hardware_interrupt = r_ip_hw;
        w_cause.software_interrupt = r_ip_sw;
        w_cause.exception_code     = r_exc_code;
    end

    // MFC0 read mux: current register contents, no write bypass
    always_comb begin
        read_data = '0;
        if (read_select == CP0_SEL_DEFAULT) begin
            case (read_register)
                CP0_REG_BADVADDR: read_data = r_bad_vaddr;
                CP0_REG_COUNT:    read_data = w_count;
                CP0_REG_COMPARE:  read_data = w_compare;
                CP0_REG_STATUS:   read_data = w_status;
                CP0_REG_CAUSE:    read_data = w_cause;
                CP0_REG_EPC:      read_data = r_epc;
                default:          read_data = '0;
            endcase
        end
    end

    assign interrupt_pending = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_mask));

    // Exception entry beats ERET beats MTC0; flush is a single-cycle pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mask        <= '0;
            r_exl         <= 1'b0;
            r_ie          <= 1'b0;
            r_bd          <= 1'b0;
            r_exc_code    <= '0;
            r_ip_hw       <= '0;
            r_ip_sw       <= '0;
            r_epc         <= '0;
            r_bad_vaddr   <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_ip_hw <= {hardware_interrupt[5] | w_timer_interrupt, hardware_interrupt[4:0]};
            r_flush <= 1'b0;
            if (exception_valid) begin
                r_exc_code <= exception_code;
                r_exl      <= 1'b1;
                // A nested exception keeps the original return address
                if (!r_exl) begin
                    r_epc <= exception_delay_slot ? exception_pc - 32'd4 : exception_pc;
                    r_bd  <= exception_delay_slot;
                end
                if (is_address_error(exception_code))
                    r_bad_vaddr <= exception_bad_vaddr;
                r_flush       <= 1'b1;
                r_redirect_pc <= EXCEPTION_VECTOR;
            end else if (eret_valid) begin
                r_exl         <= 1'b0;
                r_flush       <= 1'b1;
                r_redirect_pc <= r_epc;
            end else if (w_mtc0) begin
                case (wb_to_cp0.register_number)
                    CP0_REG_STATUS: begin
                        r_mask <= wb_to_cp0.data[15:8];
                        r_exl  <= wb_to_cp0.data[1];
                        r_ie   <= wb_to_cp0.data[0];
                    end
                    CP0_REG_CAUSE: r_ip_sw <= wb_to_cp0.data[9:8];
                    CP0_REG_EPC:   r_epc   <= wb_to_cp0.data;
                    default: ;
                endcase
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;

endmodule
